data_mem_ctrl: RTL and testbench
================================

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 16, data/address width.
REQ-002 SHALL have parameter MEM_WORDS, default 256, RAM depth in words at addresses 0..MEM_WORDS-1.
REQ-003 SHALL have parameter READ_LATENCY, default 2, processor stall cycles per RAM read; legal range 1..15.
REQ-004 SHALL have port Clock  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port DataAddr  input  WORD_SIZE  processor word address.
REQ-007 SHALL have port DataOut  input  WORD_SIZE  processor store data.
REQ-008 SHALL have port ReadData  input  1  processor load request, held while DataWaitreq=1.
REQ-009 SHALL have port WriteData  input  1  processor store request.
REQ-010 SHALL have port DataIn  output  WORD_SIZE  load result to processor.
REQ-011 SHALL have port DataWaitreq  output  1  stall request to processor.
REQ-012 SHALL have port MemAddr  output  $clog2(MEM_WORDS)  synchronous RAM address.
REQ-013 SHALL have port MemWrData  output  WORD_SIZE  RAM write data.
REQ-014 SHALL have port MemWe  output  1  RAM write enable.
REQ-015 SHALL have port MemRdData  input  WORD_SIZE  RAM read data, valid one cycle after MemAddr.
REQ-016 SHALL have port LEDR  output  10  memory-mapped LED register.
REQ-017 SHALL have port SW  input  10  memory-mapped switch inputs.
REQ-018 SHALL have port AddrErr  output  1  sticky flag for out-of-range access.

Function
REQ-019 SHALL implement FSM states IDLE, RD_WAIT, RD_DONE.
REQ-020 In IDLE, ReadData=1 to RAM range (cycle T0) SHALL drive MemAddr=DataAddr, assert DataWaitreq combinationally, load the wait counter, and enter RD_WAIT.
REQ-021 DataWaitreq SHALL stay 1 for exactly READ_LATENCY cycles (T0..T0+READ_LATENCY-1), with MemAddr held from a captured address register.
REQ-022 SHALL register MemRdData on the last RD_WAIT cycle, enter RD_DONE at T0+READ_LATENCY, drive DataIn with that value and DataWaitreq=0, then return to IDLE next cycle.
REQ-023 In RD_DONE the request SHALL be treated as consumed; a ReadData=1 seen in the following IDLE cycle SHALL start a new transaction.
REQ-024 In IDLE, WriteData=1 to RAM range SHALL complete in one cycle: MemWe=1, MemAddr=DataAddr, MemWrData=DataOut, DataWaitreq=0.
REQ-025 ReadData and WriteData both 1 SHALL service the read only, with MemWe=0.
REQ-026 An access outside RAM and outside enabled MMIO SHALL set AddrErr (sticky until Reset); writes dropped; reads take normal latency and return 0.
REQ-027 MemWe SHALL be 0 outside REQ-024; DataIn SHALL be 0 in every state other than RD_DONE and MMIO read cycles.
REQ-028 SHALL ignore ReadData/WriteData changes while in RD_WAIT; address and kind are latched at T0.

Reset
REQ-029 Reset=1 at a clock edge SHALL force IDLE, counter 0, LEDR=0, AddrErr=0, captured data 0.
REQ-030 While Reset=1, DataWaitreq, MemWe and DataIn SHALL be 0.
REQ-031 Reset mid-read SHALL abandon the transaction with no DataIn response.

Configuration
REQ-032 Macro DATA_MEM_MMIO_EN defined: 16'h1000 store latches DataOut[9:0] into LEDR; load returns LEDR zero-extended; 16'h3000 load returns SW zero-extended; MMIO loads use 0 wait states (DataWaitreq=0, DataIn valid same cycle); MMIO stores complete in one cycle with MemWe=0.
REQ-033 Macro undefined: LEDR tied 0, SW unused; 16'h1000/16'h3000 SHALL be handled as out-of-range per REQ-026.

Verification
REQ-034 Bench SHALL store 16'hBEEF to address 5, then load address 5 -> MemWe=1 one cycle, DataWaitreq=1 exactly 2 cycles, DataIn=16'hBEEF in RD_DONE.
REQ-035 Bench SHALL run READ_LATENCY=1 and 4 with back-to-back loads of addresses 3 and 4 -> stall 1/4 cycles each, correct data each, no lost or duplicated read.
REQ-036 Bench SHALL load address 16'h0200 with MEM_WORDS=256 -> AddrErr=1 and stays 1, DataIn=0, no MemWe.
REQ-037 Bench SHALL assert Reset during RD_WAIT -> next cycle IDLE, DataWaitreq=0, no RD_DONE.
REQ-038 Bench SHALL, with DATA_MEM_MMIO_EN, store 16'h02AA to 16'h1000 and load 16'h3000 with SW=10'h155 -> LEDR=10'h2AA, DataIn=16'h0155 same cycle, DataWaitreq=0.
REQ-039 Bench SHALL assert ReadData and WriteData together to address 7 -> read serviced, MemWe=0, RAM word 7 unchanged.

Source files
------------

// File: rtl/data_mem_ctrl.sv
// Data-memory controller: processor load/store to a synchronous RAM with fixed-latency read stalls.
// Optional LED/switch MMIO is enabled by defining DATA_MEM_MMIO_EN.
module data_mem_ctrl #(
    parameter int WORD_SIZE    = 16,
    parameter int MEM_WORDS    = 256,
    parameter int READ_LATENCY = 2
) (
    input  logic                         Clock,
    input  logic                         Reset,
    input  logic [WORD_SIZE-1:0]         DataAddr,
    input  logic [WORD_SIZE-1:0]         DataOut,
    input  logic                         ReadData,
    input  logic                         WriteData,
    output logic [WORD_SIZE-1:0]         DataIn,
    output logic                         DataWaitreq,
    output logic [$clog2(MEM_WORDS)-1:0] MemAddr,
    output logic [WORD_SIZE-1:0]         MemWrData,
    output logic                         MemWe,
    input  logic [WORD_SIZE-1:0]         MemRdData,
    output logic [9:0]                   LEDR,
    input  logic [9:0]                   SW,
    output logic                         AddrErr
);
    localparam int AW = $clog2(MEM_WORDS);
    localparam logic [WORD_SIZE:0] MEM_LIMIT = (WORD_SIZE+1)'(MEM_WORDS);
    localparam logic [3:0] RD_CNT = 4'(READ_LATENCY - 1);

    typedef enum logic [1:0] {IDLE, RD_WAIT, RD_DONE} state_t;

    state_t               state_q;
    logic [3:0]           cnt_q;
    logic [AW-1:0]        addr_q;
    logic [WORD_SIZE-1:0] data_q;
    logic                 rd_err_q;
    logic                 err_q;

    logic                 in_ram_d;
    logic                 is_led_d;
    logic                 is_sw_d;
    logic                 mmio_rd_d;
    logic                 start_rd_d;
    logic                 rd_bad_d;
    logic                 wr_req_d;
    logic                 wr_ram_d;
    logic                 wr_bad_d;
    logic [WORD_SIZE-1:0] mmio_data_d;
    logic [WORD_SIZE-1:0] pass_data_d;

    assign in_ram_d = ({1'b0, DataAddr} < MEM_LIMIT);

`ifdef DATA_MEM_MMIO_EN
    localparam logic [WORD_SIZE-1:0] LED_ADDR = WORD_SIZE'(16'h1000);
    localparam logic [WORD_SIZE-1:0] SW_ADDR  = WORD_SIZE'(16'h3000);

    logic [9:0] led_q;
    logic       wr_led_d;

    assign is_led_d    = !in_ram_d && (DataAddr == LED_ADDR);
    assign is_sw_d     = !in_ram_d && (DataAddr == SW_ADDR);
    assign wr_led_d    = wr_req_d && is_led_d;
    assign mmio_data_d = is_led_d ? WORD_SIZE'(led_q) : WORD_SIZE'(SW);
    assign LEDR        = led_q;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            led_q <= '0;
        end else if (state_q == IDLE && wr_led_d) begin
            led_q <= DataOut[9:0];
        end
    end
`else
    logic unused_sw;

    assign unused_sw   = ^SW;
    assign is_led_d    = 1'b0;
    assign is_sw_d     = 1'b0;
    assign mmio_data_d = '0;
    assign LEDR        = '0;
`endif

    // A simultaneous load and store is serviced as the load only.
    assign mmio_rd_d  = ReadData && (is_led_d || is_sw_d);
    assign start_rd_d = ReadData && !mmio_rd_d;
    assign rd_bad_d   = start_rd_d && !in_ram_d;
    assign wr_req_d   = WriteData && !ReadData;
    assign wr_ram_d   = wr_req_d && in_ram_d;
    assign wr_bad_d   = wr_req_d && !in_ram_d && !is_led_d;

    // With one stall cycle the RAM word only arrives in RD_DONE, so it is forwarded directly.
    generate
        if (READ_LATENCY == 1) begin : g_pass
            assign pass_data_d = rd_err_q ? '0 : MemRdData;
        end else begin : g_reg
            assign pass_data_d = '0;
        end
    endgenerate

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            rd_err_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_rd_d) begin
                        addr_q   <= DataAddr[AW-1:0];
                        rd_err_q <= rd_bad_d;
                        data_q   <= '0;
                        cnt_q    <= RD_CNT;
                        if (READ_LATENCY == 1) begin
                            state_q <= RD_DONE;
                        end else begin
                            state_q <= RD_WAIT;
                        end
                    end
                    if (rd_bad_d || wr_bad_d) begin
                        err_q <= 1'b1;
                    end
                end
                RD_WAIT: begin
                    if (cnt_q == 4'd1) begin
                        data_q  <= rd_err_q ? '0 : MemRdData;
                        cnt_q   <= '0;
                        state_q <= RD_DONE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                RD_DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign AddrErr   = err_q;
    assign MemWrData = DataOut;

    always_comb begin
        DataWaitreq = 1'b0;
        MemWe       = 1'b0;
        MemAddr     = addr_q;
        DataIn      = '0;
        if (!Reset) begin
            case (state_q)
                IDLE: begin
                    MemAddr     = DataAddr[AW-1:0];
                    DataWaitreq = start_rd_d;
                    MemWe       = wr_ram_d;
                    if (mmio_rd_d) begin
                        DataIn = mmio_data_d;
                    end
                end
                RD_WAIT: begin
                    DataWaitreq = 1'b1;
                end
                RD_DONE: begin
                    DataIn = data_q | pass_data_d;
                end
                default: begin
                    DataWaitreq = 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: three instances (READ_LATENCY 2, 1, 4), each with its own RAM model.
module tb_data_mem_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] sw  = 10'h155;

    always #5 clk = ~clk;

    logic [15:0] addr    [3];
    logic [15:0] dout    [3];
    logic        rd      [3];
    logic        wr      [3];
    logic [15:0] din     [3];
    logic        waitreq [3];
    logic [7:0]  maddr   [3];
    logic [15:0] mwdata  [3];
    logic        mwe     [3];
    logic [9:0]  led     [3];
    logic        aerr    [3];

    int total = 0;
    int bad   = 0;

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        localparam int LAT = (gi == 0) ? 2 : (gi == 1) ? 1 : 4;
        logic [15:0] mem [256];
        logic [15:0] rdata;

        always @(posedge clk) begin
            if (mwe[gi]) mem[maddr[gi]] <= mwdata[gi];
            rdata <= mem[maddr[gi]];
        end

        data_mem_ctrl #(
            .WORD_SIZE   (16),
            .MEM_WORDS   (256),
            .READ_LATENCY(LAT)
        ) u_dut (
            .Clock      (clk),
            .Reset      (rst),
            .DataAddr   (addr[gi]),
            .DataOut    (dout[gi]),
            .ReadData   (rd[gi]),
            .WriteData  (wr[gi]),
            .DataIn     (din[gi]),
            .DataWaitreq(waitreq[gi]),
            .MemAddr    (maddr[gi]),
            .MemWrData  (mwdata[gi]),
            .MemWe      (mwe[gi]),
            .MemRdData  (rdata),
            .LEDR       (led[gi]),
            .SW         (sw),
            .AddrErr    (aerr[gi])
        );
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    task automatic store(input int i, input logic [15:0] a, input logic [15:0] d,
                         input logic exp_we, input string tag);
        @(negedge clk);
        addr[i] = a; dout[i] = d; rd[i] = 1'b0; wr[i] = 1'b1;
        #1;
        check_val({tag, "_we"}, mwe[i], exp_we);
        check_val({tag, "_wait"}, waitreq[i], 0);
        if (exp_we) begin
            check_val({tag, "_maddr"}, maddr[i], a[7:0]);
            check_val({tag, "_wdata"}, mwdata[i], d);
        end
        @(negedge clk);
        wr[i] = 1'b0;
        #1;
        check_val({tag, "_we_off"}, mwe[i], 0);
    endtask

    // Holds the load while stalled; checks stall length, returned data and that nothing leaked.
    task automatic load(input int i, input logic [15:0] a, input logic also_wr,
                        input logic [15:0] exp, input int exp_stall, input string tag);
        int   stall = 0;
        logic done  = 1'b0;
        logic we_seen = 1'b0;
        logic leak  = 1'b0;
        @(negedge clk);
        addr[i] = a; dout[i] = 16'hDEAD; rd[i] = 1'b1; wr[i] = also_wr;
        for (int c = 0; c < 40 && !done; c++) begin
            #1;
            if (mwe[i]) we_seen = 1'b1;
            if (waitreq[i]) begin
                stall++;
                if (din[i] !== 16'h0) leak = 1'b1;
                @(negedge clk);
            end else begin
                done = 1'b1;
            end
        end
        check_val({tag, "_done"}, done, 1);
        check_val({tag, "_stall"}, stall, exp_stall);
        check_val({tag, "_data"}, din[i], exp);
        check_val({tag, "_no_we"}, we_seen, 0);
        check_val({tag, "_quiet"}, leak, 0);
        wr[i] = 1'b0;
    endtask

    task automatic idle_chk(input int i, input string tag);
        @(negedge clk);
        rd[i] = 1'b0; wr[i] = 1'b0;
        #1;
        check_val({tag, "_wait"}, waitreq[i], 0);
        check_val({tag, "_din"}, din[i], 0);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            addr[i] = '0; dout[i] = '0; rd[i] = 1'b0; wr[i] = 1'b0;
        end
        repeat (3) @(negedge clk);
        rd[0] = 1'b1; wr[1] = 1'b1;
        #1;
        check_val("inrst_wait0", waitreq[0], 0);
        check_val("inrst_we1", mwe[1], 0);
        check_val("inrst_din0", din[0], 0);
        @(negedge clk);
        rd[0] = 1'b0; wr[1] = 1'b0; rst = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            check_val($sformatf("rst_err%0d", i), aerr[i], 0);
            check_val($sformatf("rst_led%0d", i), led[i], 0);
            check_val($sformatf("rst_wait%0d", i), waitreq[i], 0);
        end

        // Store then load, latency 2
        store(0, 16'd5, 16'hBEEF, 1'b1, "st5");
        load(0, 16'd5, 1'b0, 16'hBEEF, 2, "ld5");

        // Load and store together: load wins, word 7 unchanged
        store(0, 16'd7, 16'h1234, 1'b1, "st7");
        load(0, 16'd7, 1'b1, 16'h1234, 2, "rdwr7");
        load(0, 16'd7, 1'b0, 16'h1234, 2, "ld7");

        // Out-of-range load: normal latency, zero data, sticky flag
        load(0, 16'h0200, 1'b0, 16'h0000, 2, "ld200");
        check_val("err_set", aerr[0], 1);
        load(0, 16'd5, 1'b0, 16'hBEEF, 2, "ld5b");
        check_val("err_sticky", aerr[0], 1);

        // Reset while in RD_WAIT
        @(negedge clk);
        addr[0] = 16'd5; rd[0] = 1'b1;
        #1;
        check_val("rr_t0_wait", waitreq[0], 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_val("rr_inrst_wait", waitreq[0], 0);
        check_val("rr_inrst_din", din[0], 0);
        @(negedge clk);
        rst = 1'b0; rd[0] = 1'b0;
        #1;
        check_val("rr_after_wait", waitreq[0], 0);
        check_val("rr_after_din", din[0], 0);
        check_val("rr_err_clr", aerr[0], 0);
        idle_chk(0, "rr_idle");

        // Back-to-back loads, latency 1 and 4
        store(1, 16'd3, 16'h0A03, 1'b1, "l1_st3");
        store(1, 16'd4, 16'h0B04, 1'b1, "l1_st4");
        load(1, 16'd3, 1'b0, 16'h0A03, 1, "l1_ld3");
        load(1, 16'd4, 1'b0, 16'h0B04, 1, "l1_ld4");
        idle_chk(1, "l1_idle");
        store(2, 16'd3, 16'h5A03, 1'b1, "l4_st3");
        store(2, 16'd4, 16'h5B04, 1'b1, "l4_st4");
        load(2, 16'd3, 1'b0, 16'h5A03, 4, "l4_ld3");
        load(2, 16'd4, 1'b0, 16'h5B04, 4, "l4_ld4");
        idle_chk(2, "l4_idle");

`ifdef DATA_MEM_MMIO_EN
        store(0, 16'h1000, 16'h02AA, 1'b0, "mm_st_led");
        check_val("mm_ledr", led[0], 10'h2AA);
        load(0, 16'h3000, 1'b0, 16'h0155, 0, "mm_ld_sw");
        load(0, 16'h1000, 1'b0, 16'h02AA, 0, "mm_ld_led");
        check_val("mm_no_err", aerr[0], 0);
`else
        store(0, 16'h1000, 16'h02AA, 1'b0, "nomm_st_led");
        check_val("nomm_ledr", led[0], 0);
        check_val("nomm_err_st", aerr[0], 1);
        load(0, 16'h3000, 1'b0, 16'h0000, 2, "nomm_ld_sw");
        check_val("nomm_err_ld", aerr[0], 1);
`endif
        idle_chk(0, "end_idle");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
